// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard receive FIFO peripheral: register word
// addresses, STATUS/CTRL bit positions and the DATA word layout.
package ps2_kbd_pkg;

    localparam int unsigned CHAR_W = 7;

    // Word addresses on the peripheral bus
    localparam logic [1:0] KBD_ADDR_DATA   = 2'd0;
    localparam logic [1:0] KBD_ADDR_STATUS = 2'd1;
    localparam logic [1:0] KBD_ADDR_CTRL   = 2'd2;

    // STATUS register layout
    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_IRQEN_BIT = 3;
    localparam int unsigned STAT_COUNT_LSB = 8;

    // CTRL register layout
    localparam int unsigned CTRL_FLUSH_BIT = 0;

    // DATA register layout: valid flag above the character
    localparam int unsigned DATA_VALID_BIT = 8;

    // Build the DATA read word for a popped character.
    function automatic logic [31:0] pack_data(input logic [CHAR_W-1:0] ch);
        logic [31:0] word;
        word                 = '0;
        word[CHAR_W-1:0]     = ch;
        word[DATA_VALID_BIT] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/kbd_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with push, pop, flush and occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
// Flush clears pointers and count and overrides push/pop.
module kbd_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 7,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + CNT_W'(1);
            else if (!push_ok && pop_ok) count_q <= count_q - CNT_W'(1);
        end
    end

    // Storage array, written only on an accepted, unflushed push
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard receive buffer: acknowledges characters from the keyboard front end,
// queues them in a FIFO and exposes DATA/STATUS/CTRL registers on the peripheral bus.
// Optional macro PS2_KBD_IRQ_EN adds an irq_enable bit and the kbd_irq output.
module ps2_kbd_fifo
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CHAR_W-1:0] ascii_code,
    input  logic              ascii_data_ready,
    output logic              rx_ascii_read,
    input  logic              bus_en,
    input  logic              bus_we,
    input  logic [1:0]        bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic [31:0]       bus_rdata,
    output logic              kbd_irq
);

    logic              ack_q;
    logic              capture, push_req, pop_req, flush;
    logic              rd_en, wr_en, ovf_clr, dropped;
    logic              ovf_q;
    logic [31:0]       rdata_q, rdata_d, status_word;
    logic [CHAR_W-1:0] fifo_rdata;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              unused_wdata;

    assign unused_wdata = ^bus_wdata;

    // A ready level seen during our own acknowledge cycle is the same character
    assign capture  = ascii_data_ready & ~ack_q;
    assign rd_en    = bus_en & ~bus_we;
    assign wr_en    = bus_en & bus_we;
    assign flush    = wr_en & (bus_addr == KBD_ADDR_CTRL) & bus_wdata[CTRL_FLUSH_BIT];
    assign ovf_clr  = wr_en & (bus_addr == KBD_ADDR_STATUS) & bus_wdata[STAT_OVF_BIT];
    assign pop_req  = rd_en & (bus_addr == KBD_ADDR_DATA) & ~fifo_empty;
    assign push_req = capture & ~flush;
    assign dropped  = push_req & fifo_full & ~pop_req;

    kbd_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CHAR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop_req),
        .flush (flush),
        .wdata (ascii_code),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef PS2_KBD_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;
    logic nonempty_next;

    assign irq_en_d = (wr_en && bus_addr == KBD_ADDR_STATUS) ? bus_wdata[STAT_IRQEN_BIT]
                                                             : irq_en_q;
    // Occupancy after this edge, so the IRQ tracks the FIFO without an extra cycle of lag
    assign nonempty_next = ~flush & (push_req | (fifo_count > CNT_W'(1)) |
                                     (~fifo_empty & ~pop_req));
    assign irq_d   = irq_en_d & nonempty_next;
    assign kbd_irq = irq_q;

    // Interrupt enable and registered interrupt level
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`else
    assign kbd_irq = 1'b0;
`endif

    // STATUS word reflects state before any push/pop of the current cycle
    always_comb begin
        status_word                          = '0;
        status_word[STAT_EMPTY_BIT]          = fifo_empty;
        status_word[STAT_FULL_BIT]           = fifo_full;
        status_word[STAT_OVF_BIT]            = ovf_q;
`ifdef PS2_KBD_IRQ_EN
        status_word[STAT_IRQEN_BIT]          = irq_en_q;
`else
        status_word[STAT_IRQEN_BIT]          = 1'b0;
`endif
        status_word[STAT_COUNT_LSB +: CNT_W] = fifo_count;
    end

    // Read data mux; bus_rdata holds its value between reads
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            unique case (bus_addr)
                KBD_ADDR_DATA:   rdata_d = fifo_empty ? 32'd0 : pack_data(fifo_rdata);
                KBD_ADDR_STATUS: rdata_d = status_word;
                default:         rdata_d = 32'd0;
            endcase
        end
    end

    // Acknowledge pulse, sticky overflow and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= capture;
            rdata_q <= rdata_d;
            // A new drop in the same cycle as a clear leaves the flag set
            if (dropped)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    assign rx_ascii_read = ack_q;
    assign bus_rdata     = rdata_q;

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Directed self-checking bench for ps2_kbd_fifo (DEPTH=16).
// IRQ checks adapt to whether PS2_KBD_IRQ_EN is defined.
module tb_ps2_kbd_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  ascii_code;
    logic        ascii_data_ready;
    logic        rx_ascii_read;
    logic        bus_en, bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        kbd_irq;

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;

    ps2_kbd_fifo #(.DEPTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .ascii_code       (ascii_code),
        .ascii_data_ready (ascii_data_ready),
        .rx_ascii_read    (rx_ascii_read),
        .bus_en           (bus_en),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_rdata        (bus_rdata),
        .kbd_irq          (kbd_irq)
    );

    always #5 clk = ~clk;

    // Count acknowledge pulses seen at active edges
    always @(posedge clk) begin
        if (rx_ascii_read) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = addr;
        tick();
        bus_en = 1'b0;
        data = bus_rdata;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] wdata);
        bus_en = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = wdata;
        tick();
        bus_en = 1'b0; bus_we = 1'b0; bus_wdata = '0;
    endtask

    // Front end: raise ready, hold it through the acknowledge cycle, then drop it
    task automatic send_char(input logic [6:0] c);
        ascii_code = c;
        ascii_data_ready = 1'b1;
        tick();
        tick();
        ascii_data_ready = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        int p0;

        rst = 1'b1; ascii_code = '0; ascii_data_ready = 1'b0;
        bus_en = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("reset_ack", 32'(rx_ascii_read), 32'd0);
        check("reset_rdata", bus_rdata, 32'd0);
        check("reset_irq", 32'(kbd_irq), 32'd0);
        bus_read(2'd1, rd);
        check("reset_status", rd, 32'h1);

        // Single 'A' with ready held for two cycles
        p0 = pulse_cnt;
        ascii_code = 7'h41; ascii_data_ready = 1'b1;
        tick();
        check("A_ack_high", 32'(rx_ascii_read), 32'd1);
        tick();
        check("A_ack_single", 32'(rx_ascii_read), 32'd0);
        ascii_data_ready = 1'b0;
        tick();
        check("A_pulses", 32'(pulse_cnt - p0), 32'd1);
        bus_read(2'd1, rd);
        check("A_status_cnt1", rd, 32'h100);
        bus_read(2'd0, rd);
        check("A_data", rd, 32'h141);
        bus_read(2'd1, rd);
        check("A_status_empty", rd, 32'h1);

        // 17 characters into a 16-entry FIFO
        p0 = pulse_cnt;
        for (int i = 0; i < 17; i++) send_char(7'(8'h30 + i));
        check("ovf_pulses", 32'(pulse_cnt - p0), 32'd17);
        bus_read(2'd1, rd);
        check("ovf_status", rd, 32'h1006);
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, rd);
            check($sformatf("ovf_data%0d", i), rd, 32'h130 + 32'(i));
        end
        bus_read(2'd0, rd);
        check("ovf_data_empty", rd, 32'd0);
        bus_read(2'd1, rd);
        check("ovf_status_drained", rd, 32'h5);

        // Refill, clear overflow, then push 'Z' during a pop while full
        for (int i = 0; i < 16; i++) send_char(7'(8'h50 + i));
        bus_read(2'd1, rd);
        check("refill_status", rd, 32'h1006);
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, rd);
        check("ovf_cleared", rd, 32'h1002);
        ascii_code = 7'h5A; ascii_data_ready = 1'b1;
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = 2'd0;
        tick();
        bus_en = 1'b0;
        check("fullpop_data", bus_rdata, 32'h150);
        check("fullpop_ack", 32'(rx_ascii_read), 32'd1);
        tick();
        ascii_data_ready = 1'b0;
        bus_read(2'd1, rd);
        check("fullpop_status", rd, 32'h1002);
        for (int i = 1; i < 16; i++) begin
            bus_read(2'd0, rd);
            check($sformatf("fullpop_data%0d", i), rd, 32'h150 + 32'(i));
        end
        bus_read(2'd0, rd);
        check("fullpop_Z_last", rd, 32'h15A);

        // Overflow again, then flush keeps overflow
        for (int i = 0; i < 17; i++) send_char(7'h20);
        bus_write(2'd2, 32'h1);
        bus_read(2'd1, rd);
        check("flush_status", rd, 32'h5);
        bus_write(2'd1, 32'h4);
        bus_read(2'd2, rd);
        check("ctrl_read", rd, 32'd0);
        bus_read(2'd3, rd);
        check("rsvd_read", rd, 32'd0);

        // Push concurrent with STATUS read sees pre-push state
        ascii_code = 7'h31; ascii_data_ready = 1'b1;
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = 2'd1;
        tick();
        bus_en = 1'b0;
        check("push_status_pre", bus_rdata, 32'h1);
        tick();
        ascii_data_ready = 1'b0;
        bus_read(2'd1, rd);
        check("push_status_post", rd, 32'h100);
        bus_read(2'd0, rd);
        check("push_status_data", rd, 32'h131);

        // Interrupt
`ifdef PS2_KBD_IRQ_EN
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, rd);
        check("irq_en_status", rd, 32'h9);
        ascii_code = 7'h71; ascii_data_ready = 1'b1;
        tick();
        tick();
        ascii_data_ready = 1'b0;
        check("irq_rise", 32'(kbd_irq), 32'd1);
        tick();
        bus_read(2'd0, rd);
        check("irq_data", rd, 32'h171);
        check("irq_fall", 32'(kbd_irq), 32'd0);
        bus_write(2'd1, 32'h0);
        send_char(7'h72);
        check("irq_disabled", 32'(kbd_irq), 32'd0);
        bus_read(2'd0, rd);
        check("irq_dis_data", rd, 32'h172);
`else
        bus_write(2'd1, 32'h8);
        bus_read(2'd1, rd);
        check("irq_en_status", rd, 32'h1);
        send_char(7'h71);
        check("irq_absent", 32'(kbd_irq), 32'd0);
        bus_read(2'd0, rd);
        check("irq_data", rd, 32'h171);
`endif

        // Reset mid-stream with an outstanding pulse and a still-pending character
        for (int i = 0; i < 5; i++) send_char(7'(8'h61 + i));
        bus_read(2'd1, rd);
        check("pre_rst_status", rd, 32'h500);
        ascii_code = 7'h66; ascii_data_ready = 1'b1;
        tick();
        check("pre_rst_ack", 32'(rx_ascii_read), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_ack", 32'(rx_ascii_read), 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_irq", 32'(kbd_irq), 32'd0);
        p0 = pulse_cnt;
        tick();
        check("rst_recapture", 32'(rx_ascii_read), 32'd1);
        tick();
        ascii_data_ready = 1'b0;
        tick();
        check("rst_pulses", 32'(pulse_cnt - p0), 32'd1);
        bus_read(2'd1, rd);
        check("rst_status", rd, 32'h100);
        bus_read(2'd0, rd);
        check("rst_data", rd, 32'h166);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
